// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the reset PC, the NOP encoding and the RISC-V major opcodes.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h4000_0000;
  localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;

  // Major opcodes; fetch only forwards bits [6:0], decode interprets them.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side handshake signals.
// master = fetch stage, slave = its environment (memory, execute, decode).
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;
  logic            fetch_misalign;

  modport master (
    output imem_en, imem_addr, id_valid, id_instr, id_pc, id_opcode, fetch_misalign,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_en, imem_addr, id_valid, id_instr, id_pc, id_opcode, fetch_misalign,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry {instr, pc} FIFO between the instruction memory and decode.
// Flush wins over a simultaneous push so a wrong-path return is never stored.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-flight tracking and credit-based issue into a
// 2-entry skid buffer; execute redirects flush all wrong-path work.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master fe_if
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            misalign_q, misalign_d;

  logic [1:0]      buf_count;
  fetch_entry_t    buf_head;
  fetch_entry_t    ret_entry;
  logic            id_valid_int;
  logic            pop;
  logic            issue;
  logic [2:0]      credits_used;
  logic [XLEN-1:0] fetch_addr;

  assign id_valid_int = (buf_count != 2'd0) & ~fe_if.redirect_valid;
  assign pop          = id_valid_int & fe_if.id_ready;

  // Words already committed to the buffer: queued plus in flight, minus what leaves now.
  assign credits_used = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue        = rst_n & (fe_if.redirect_valid | (credits_used < 3'd2));
  assign fetch_addr   = fe_if.redirect_valid ? align_word(fe_if.redirect_pc) : pc_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = fetch_addr;
    misalign_d    = fe_if.redirect_valid & fe_if.redirect_pc[1];
    if (issue) pc_d = fetch_addr + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  // With one-cycle memory latency a wrong-path word always returns in the
  // redirect cycle itself, where the buffer flush discards it.
  assign ret_entry.instr = fe_if.imem_rdata;
  assign ret_entry.pc    = inflight_pc_q;

  fetch_skid_buf u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .flush_i (fe_if.redirect_valid),
    .entry_i (ret_entry),
    .count_o (buf_count),
    .head_o  (buf_head)
  );

  assign fe_if.imem_en        = issue;
  assign fe_if.imem_addr      = fetch_addr;
  assign fe_if.id_valid       = id_valid_int;
  assign fe_if.id_instr       = id_valid_int ? buf_head.instr : NOP_INSTR;
  assign fe_if.id_pc          = id_valid_int ? buf_head.pc : '0;
  assign fe_if.id_opcode      = fe_if.id_instr[6:0];
  assign fe_if.fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle table for directed corners plus
// an issue/consume scoreboard running on every cycle, including random traffic.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fe_if (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:7] ^ 25'h1A5_A5A5, a[8:2] ^ {5'b0, a[1:0]}};
  endfunction

  always @(posedge clk)
    bus.imem_rdata <= bus.imem_en ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  typedef struct { logic [31:0] pc; int cyc; } sb_t;
  sb_t         sb[$];
  int          cyc = 0;
  logic [31:0] model_pc = BASE;
  logic        prev_mis = 1'b0;

  initial begin
    logic        exp_valid, exp_en;
    logic [31:0] exp_addr;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (!rst_n) begin
        chk("rst_imem_en", {31'b0, bus.imem_en}, 32'd0);
        chk("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("rst_id_instr", bus.id_instr, NOP_INSTR);
        chk("rst_misalign", {31'b0, bus.fetch_misalign}, 32'd0);
        sb.delete();
        model_pc = BASE;
        prev_mis = 1'b0;
        continue;
      end
      chk("sb_misalign", {31'b0, bus.fetch_misalign}, {31'b0, prev_mis});
      if (bus.redirect_valid) sb.delete();
      exp_valid = !bus.redirect_valid && sb.size() > 0 && sb[0].cyc <= cyc - 2;
      if (exp_valid) begin
        chk("sb_id_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("sb_id_pc", bus.id_pc, sb[0].pc);
        chk("sb_id_instr", bus.id_instr, mem_word(sb[0].pc));
        chk("sb_id_opcode", {25'b0, bus.id_opcode}, {25'b0, mem_word(sb[0].pc) & 32'h7F} );
        if (bus.id_ready) begin
          $display("txn pc=%h instr=%h", bus.id_pc, bus.id_instr);
          void'(sb.pop_front());
        end
      end else begin
        chk("sb_id_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("sb_idle_pc", bus.id_pc, 32'd0);
        chk("sb_idle_instr", bus.id_instr, NOP_INSTR);
      end
      exp_en = bus.redirect_valid || sb.size() < 2;
      chk("sb_imem_en", {31'b0, bus.imem_en}, {31'b0, exp_en});
      if (exp_en) begin
        exp_addr = bus.redirect_valid ? {bus.redirect_pc[31:2], 2'b00} : model_pc;
        chk("sb_imem_addr", bus.imem_addr, exp_addr);
        sb.push_back('{pc: exp_addr, cyc: cyc});
        model_pc = exp_addr + 32'd4;
      end
      prev_mis = bus.redirect_valid & bus.redirect_pc[1];
    end
  end

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic        rst_n, ready, redir;
    logic [31:0] rpc;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic en, input logic [31:0] addr, input logic v,
                     input logic [31:0] pc, input logic mis);
    vecs.push_back('{r, rdy, rv, rpc, en, addr, v, pc, mis});
  endtask

  initial begin
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, BASE, 0, 0, 0);
    add(1, 1, 0, 0, 1, BASE + 4, 0, 0, 0);
    for (int k = 2; k < 10; k++) add(1, 1, 0, 0, 1, BASE + 4 * k, 1, BASE + 4 * (k - 2), 0);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 0, 0, 0, 1, BASE + 32'h20, 0);
    add(1, 1, 0, 0, 1, BASE + 32'h28, 1, BASE + 32'h20, 0);
    add(1, 1, 0, 0, 1, BASE + 32'h2C, 1, BASE + 32'h24, 0);
    add(1, 1, 0, 0, 1, BASE + 32'h30, 1, BASE + 32'h28, 0);
    add(1, 1, 1, BASE + 32'h100, 1, BASE + 32'h100, 0, 0, 0);
    add(1, 1, 0, 0, 1, BASE + 32'h104, 0, 0, 0);
    add(1, 1, 0, 0, 1, BASE + 32'h108, 1, BASE + 32'h100, 0);
    add(1, 1, 0, 0, 1, BASE + 32'h10C, 1, BASE + 32'h104, 0);
    add(1, 1, 1, BASE + 32'h202, 1, BASE + 32'h200, 0, 0, 0);
    add(1, 1, 0, 0, 1, BASE + 32'h204, 0, 0, 1);
    add(1, 1, 0, 0, 1, BASE + 32'h208, 1, BASE + 32'h200, 0);
    add(1, 1, 0, 0, 1, BASE + 32'h20C, 1, BASE + 32'h204, 0);
    add(1, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 0);
    add(1, 1, 0, 0, 1, 32'h0000_0000, 0, 0, 0);
    add(1, 1, 0, 0, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 0);
    add(1, 1, 0, 0, 1, 32'h0000_0008, 1, 32'h0000_0000, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, BASE, 0, 0, 0);
    add(1, 1, 0, 0, 1, BASE + 4, 0, 0, 0);
    add(1, 1, 0, 0, 1, BASE + 8, 1, BASE, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n              = vecs[i].rst_n;
      bus.id_ready       = vecs[i].ready;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      #3;
      chk($sformatf("v%0d_imem_en", i), {31'b0, bus.imem_en}, {31'b0, vecs[i].exp_en});
      if (vecs[i].exp_en)
        chk($sformatf("v%0d_imem_addr", i), bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_id_valid", i), {31'b0, bus.id_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_id_pc", i), bus.id_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_id_instr", i), bus.id_instr,
          vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : NOP_INSTR);
      chk($sformatf("v%0d_misalign", i), {31'b0, bus.fetch_misalign}, {31'b0, vecs[i].exp_mis});
    end

    // Random backpressure and redirects, checked by the scoreboard.
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_pc    = $urandom;
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    repeat (4) @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 3-stage RISC-V core: owns the PC, issues reads to the synchronous instruction memory (1-cycle read latency), and buffers returned words in a 2-entry queue with a valid/ready handshake toward the pre-decoder. It supplies the instruction word and its 7-bit opcode field that the decode stage consumes. It also accepts redirects (taken branch or jump) from execute and kills all wrong-path work.

## Interface
- `XLEN`, 32: datapath width (from `defines.v`).
- `RESET_PC`, 32'h4000_0000: first fetch address after reset.
- `clk`  in  1  core clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_en`  out  1  read enable; one request per cycle when high.
- `imem_addr`  out  XLEN  byte address of the request; bits [1:0] are always 0.
- `imem_rdata`  in  32  instruction word, valid the cycle after `imem_en`.
- `redirect_valid`  in  1  single-cycle pulse from execute.
- `redirect_pc`  in  XLEN  redirect target.
- `id_ready`  in  1  decode can accept this cycle.
- `id_valid`  out  1  head entry presented.
- `id_instr`  out  32  head instruction; 32'h0000_0013 (NOP) when not valid.
- `id_pc`  out  XLEN  head PC; 0 when not valid.
- `id_opcode`  out  7  `id_instr[6:0]`.
- `fetch_misalign`  out  1  registered one-cycle pulse: redirect target had `redirect_pc[1] = 1`.

## Operation
- State:
  - `pc_q`: next address to fetch.
  - `inflight_q`: a request was issued last cycle.
  - `inflight_pc_q`: PC of that request.
  - `kill_q`: the in-flight request must be discarded.
  - Queue: 2 entries of {instr, pc}, with read/write pointers and a 2-bit count.
- Issue rule: issue when `count + inflight_q - pop < 2`, where `pop = id_valid & id_ready`.
  - On issue: `imem_en = 1`, `imem_addr = pc_q`, and `pc_q <= pc_q + 4`, modulo 2^XLEN (wraps silently).
- Return: when `inflight_q & ~kill_q`, write {`imem_rdata`, `inflight_pc_q`} into the queue.
  - The credit rule guarantees a free slot, so overflow is impossible.
- Output: `id_valid = (count != 0) & ~redirect_valid`. The head entry drives `id_instr` and `id_pc`.
- Redirect cycle (`redirect_valid = 1`):
  - Flush the queue: count becomes 0 and pointers reset.
  - Set `kill_q` if a request is in flight this cycle.
  - Issue unconditionally with `imem_addr = {redirect_pc[XLEN-1:2], 2'b00}` and set `pc_q <= that + 4`.
  - Any pop in this cycle is suppressed, because `id_valid` is gated low.
  - If `redirect_pc[1]` is set, `fetch_misalign` pulses next cycle; the fetch still proceeds at the aligned address.
- Simultaneous return and pop: write and read occur together and count is unchanged.
- Reset (any time, asynchronous):
  - `pc_q = RESET_PC`; queue empty; `inflight_q = 0`; `kill_q = 0`; `fetch_misalign = 0`.
  - Outputs while reset is asserted: `imem_en = 0`, `id_valid = 0`.
  - A return arriving after reset deasserts is ignored, because `inflight_q` was cleared.

## Timing
- Issue at cycle t → data in the queue at the end of t+1 → `id_valid` high at cycle t+2. Start-up latency is 2 cycles.
- Steady throughput is 1 instruction per cycle while `id_ready` is held high.
- Backpressure: with `id_ready` low, at most 2 words are held (queued plus in flight), then `imem_en` drops. It reissues the cycle a pop frees a credit.
- Redirect penalty: redirect at cycle r → first correct-path `id_valid` at r+2.
- Combinational paths: `redirect_valid` → `id_valid` and `imem_addr`; `id_ready` → `imem_en`. No path from `imem_rdata` to any output.

## Structure
- `RESET_PC` default and the NOP encoding 32'h0000_0013 go in `defines.v`.
- Opcode constants come from `Opcode.vh`; this block does not decode them.
- One sub-module, `fetch_skid_buf`: a 2-entry {instr, pc} FIFO with push, pop, flush, count, and head outputs.
- `fetch_stage` itself holds only the PC, the in-flight tracking, and the credit logic.

## Test plan
- Reset: hold `rst_n` low for 3 cycles, then release.
  - During reset: `imem_en = 0`, `id_valid = 0`, `id_instr = 32'h13`.
  - First issue at 32'h4000_0000; `id_valid` high 2 cycles later with `id_pc = 32'h4000_0000`.
- Streaming with `id_ready = 1` for 8 cycles:
  - `id_pc` runs 4000_0000, _0004, _0008, … on consecutive cycles.
  - `id_opcode` matches the memory model's bits [6:0].
- Stall: drop `id_ready` for 5 cycles.
  - `imem_en` deasserts after 2 outstanding words.
  - On release: no instruction lost or duplicated; PCs stay contiguous.
- Redirect with a request in flight: pulse `redirect_valid` with `redirect_pc = 32'h4000_0100`.
  - The in-flight word is discarded and the queue flushed.
  - `imem_addr = 32'h4000_0100` that cycle; next `id_pc = 32'h4000_0100` at r+2.
- Misaligned redirect plus concurrent pop: `redirect_pc = 32'h4000_0202` with `id_ready = 1`.
  - No pop occurs; `fetch_misalign` pulses one cycle.
  - Fetch proceeds at 32'h4000_0200.
- Reset mid-operation and wrap-around:
  - Assert `rst_n` low mid-stream: all state clears immediately.
  - Redirect to 32'hFFFF_FFFC: the next fetch is 32'h0000_0000.
